// File: rtl/instr_load_if.sv
// rtl/instr_load_if.sv - front panel / checker / pipeline signal bundle for instr_load_ctrl
interface instr_load_if #(
    parameter int NUM_INSTR = 8
);
    localparam int PW = $clog2(NUM_INSTR + 1);

    logic [7:0]             input_val;
    logic                   but_inp;
    logic                   but_check;
    logic                   check_done;
    logic                   run_done;
    logic [8*NUM_INSTR-1:0] instrMemBits;
    logic [PW-1:0]          wr_ptr;
    logic                   check_start;
    logic                   run_en;
    logic [1:0]             state_o;

    modport slave (
        input  input_val, but_inp, but_check, check_done, run_done,
        output instrMemBits, wr_ptr, check_start, run_en, state_o
    );

    modport master (
        output input_val, but_inp, but_check, check_done, run_done,
        input  instrMemBits, wr_ptr, check_start, run_en, state_o
    );
endinterface

// File: rtl/instr_load_ctrl.sv
// rtl/instr_load_ctrl.sv - button-driven instruction loader sequencing LOAD/CHECK/RUN/DONE
module instr_load_ctrl #(
    parameter int NUM_INSTR = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    instr_load_if.slave  bus
);
    localparam int W  = 8 * NUM_INSTR;
    localparam int PW = $clog2(NUM_INSTR + 1);
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_INSTR - 1);
    localparam logic [PW-1:0] FULL = PW'(NUM_INSTR);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Index 0 is the load button, index 1 the check button.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_acc;
    logic [1:0]    r_prev;
    logic [CW-1:0] r_cnt [2];

    state_t        r_state;
    logic [W-1:0]  r_image;
    logic [PW-1:0] r_wr_ptr;
    logic          r_check_start;
    logic          r_run_en;

    logic          w_load_ev;
    logic          w_check_ev;
    logic [W-1:0]  w_slot;

    assign w_raw      = {bus.but_check, bus.but_inp};
    assign w_load_ev  = r_acc[0] ^ r_prev[0];
    assign w_check_ev = r_acc[1] & ~r_prev[1];
    // Unwritten slots are always zero, so OR-ing the shifted byte is a slot write.
    assign w_slot     = W'(bus.input_val) << {r_wr_ptr, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_acc   <= '0;
            r_prev  <= '0;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_acc;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_acc[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CW'(DB_CYCLES - 1)) begin
                    r_acc[b] <= r_sync2[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_LOAD;
            r_image       <= '0;
            r_wr_ptr      <= '0;
            r_check_start <= 1'b0;
            r_run_en      <= 1'b0;
        end else begin
            r_check_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_load_ev && r_wr_ptr != FULL) begin
                        r_image  <= r_image | w_slot;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    // A same-cycle load counts toward the non-empty requirement.
                    if ((w_load_ev && r_wr_ptr == LAST) ||
                        (w_check_ev && (r_wr_ptr != '0 || w_load_ev))) begin
                        r_state       <= S_CHECK;
                        r_check_start <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (bus.check_done) begin
                        r_state  <= S_RUN;
                        r_run_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.run_done) begin
                        r_state  <= S_DONE;
                        r_run_en <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (w_load_ev) begin
                        r_state  <= S_LOAD;
                        r_image  <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.instrMemBits = r_image;
    assign bus.wr_ptr       = r_wr_ptr;
    assign bus.check_start  = r_check_start;
    assign bus.run_en       = r_run_en;
    assign bus.state_o      = r_state;
endmodule

// File: tb/tb_instr_load_ctrl.sv
// tb/tb_instr_load_ctrl.sv - vector table, corner sequences and random model check of instr_load_ctrl
module tb_instr_load_ctrl;
    localparam int N    = 8;
    localparam int DB   = 4;
    localparam int HOLD = DB + 8;

    typedef enum int {OP_LOAD, OP_CHECK, OP_GLITCH, OP_CDONE, OP_RDONE} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  data;
        logic [1:0]  st;
        logic [3:0]  wr;
        logic [63:0] img;
        int          cs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    instr_load_if #(.NUM_INSTR(N)) bus ();

    instr_load_ctrl #(.NUM_INSTR(N), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cs_seen = 0;
    int   cs_run = 0;
    int   cs_wide = 0;
    logic lvl = 1'b0;

    int         m_state;
    logic [7:0] m_q [$];
    int         m_cs = 0;
    vec_t       vt [$];

    always @(negedge clk) begin
        if (bus.check_start === 1'b1) begin
            cs_seen++;
            cs_run++;
            if (cs_run > 1) cs_wide++;
        end else begin
            cs_run = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] m_img();
        logic [63:0] v = '0;
        foreach (m_q[i]) v = v | (64'(m_q[i]) << (8 * i));
        return v;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_q.delete();
    endfunction

    function automatic void model_apply(input op_e op, input logic [7:0] d);
        case (op)
            OP_LOAD: begin
                if (m_state == 0) begin
                    m_q.push_back(d);
                    if (m_q.size() == N) begin
                        m_state = 1;
                        m_cs++;
                    end
                end else if (m_state == 3) begin
                    m_q.delete();
                    m_state = 0;
                end
            end
            OP_CHECK: if (m_state == 0 && m_q.size() >= 1) begin
                m_state = 1;
                m_cs++;
            end
            OP_CDONE: if (m_state == 1) m_state = 2;
            OP_RDONE: if (m_state == 2) m_state = 3;
            default: ;
        endcase
    endfunction

    task automatic do_op(input op_e op, input logic [7:0] d);
        case (op)
            OP_LOAD: begin
                bus.input_val = d;
                lvl = ~lvl;
                bus.but_inp = lvl;
                wait_cyc(HOLD);
            end
            OP_CHECK: begin
                bus.but_check = 1'b1;
                wait_cyc(HOLD);
                bus.but_check = 1'b0;
                wait_cyc(HOLD);
            end
            OP_GLITCH: begin
                bus.but_inp = ~lvl;
                wait_cyc(DB - 1);
                bus.but_inp = lvl;
                wait_cyc(HOLD);
            end
            OP_CDONE: begin
                bus.check_done = 1'b1;
                wait_cyc(1);
                bus.check_done = 1'b0;
            end
            OP_RDONE: begin
                bus.run_done = 1'b1;
                wait_cyc(1);
                bus.run_done = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, bus.state_o, m_state);
        chk({tag, "_wr_ptr"}, bus.wr_ptr, m_q.size());
        chk({tag, "_image"}, bus.instrMemBits, m_img());
        chk({tag, "_run_en"}, bus.run_en, m_state == 2);
        chk({tag, "_cs_count"}, cs_seen, m_cs);
    endtask

    task automatic reset_dut();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", bus.state_o, 0);
        chk("async_rst_wr_ptr", bus.wr_ptr, 0);
        chk("async_rst_image", bus.instrMemBits, 0);
        chk("async_rst_run_en", bus.run_en, 0);
        lvl = 1'b0;
        bus.but_inp = 1'b0;
        bus.but_check = 1'b0;
        bus.check_done = 1'b0;
        bus.run_done = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        model_reset();
    endtask

    function automatic void add(input op_e op, input logic [7:0] d, input logic [1:0] st,
                                input logic [3:0] wr, input logic [63:0] img, input int cs);
        vec_t v;
        v.op = op; v.data = d; v.st = st; v.wr = wr; v.img = img; v.cs = cs;
        vt.push_back(v);
    endfunction

    initial begin
        logic [7:0] seq [8] = '{8'hCA, 8'hDC, 8'h59, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [63:0] img_acc;
        logic found;

        bus.input_val = '0;
        bus.but_inp = 1'b0;
        bus.but_check = 1'b0;
        bus.check_done = 1'b0;
        bus.run_done = 1'b0;

        @(negedge clk);
        chk("rst_state", bus.state_o, 0);
        chk("rst_wr_ptr", bus.wr_ptr, 0);
        chk("rst_image", bus.instrMemBits, 0);
        chk("rst_check_start", bus.check_start, 0);
        chk("rst_run_en", bus.run_en, 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);

        add(OP_CHECK,  8'h00, 2'd0, 4'd0, 64'h0,    0);
        add(OP_LOAD,   8'hCA, 2'd0, 4'd1, 64'hCA,   0);
        add(OP_GLITCH, 8'h00, 2'd0, 4'd1, 64'hCA,   0);
        add(OP_LOAD,   8'hDC, 2'd0, 4'd2, 64'hDCCA, 0);
        add(OP_CHECK,  8'h00, 2'd1, 4'd2, 64'hDCCA, 1);
        add(OP_LOAD,   8'h55, 2'd1, 4'd2, 64'hDCCA, 1);
        add(OP_CDONE,  8'h00, 2'd2, 4'd2, 64'hDCCA, 1);
        add(OP_RDONE,  8'h00, 2'd3, 4'd2, 64'hDCCA, 1);
        add(OP_LOAD,   8'h77, 2'd0, 4'd0, 64'h0,    1);
        img_acc = '0;
        for (int i = 0; i < 8; i++) begin
            img_acc = img_acc | (64'(seq[i]) << (8 * i));
            add(OP_LOAD, seq[i], (i == 7) ? 2'd1 : 2'd0, 4'(i + 1), img_acc, (i == 7) ? 2 : 1);
        end

        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].data);
            chk($sformatf("vec%0d_state", i), bus.state_o, vt[i].st);
            chk($sformatf("vec%0d_wr_ptr", i), bus.wr_ptr, vt[i].wr);
            chk($sformatf("vec%0d_image", i), bus.instrMemBits, vt[i].img);
            chk($sformatf("vec%0d_run_en", i), bus.run_en, vt[i].st == 2'd2);
            chk($sformatf("vec%0d_cs_count", i), cs_seen, vt[i].cs);
        end
        m_cs = cs_seen;

        reset_dut();
        for (int i = 0; i < 3; i++) begin
            do_op(OP_LOAD, 8'h11 * (i + 1));
            model_apply(OP_LOAD, 8'h11 * (i + 1));
        end
        check_model("three_loads");
        reset_dut();
        do_op(OP_LOAD, 8'h44);
        model_apply(OP_LOAD, 8'h44);
        chk("post_rst_slot0", bus.instrMemBits, 64'h44);
        chk("post_rst_wr_ptr", bus.wr_ptr, 1);

        bus.but_check = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.check_start === 1'b1) found = 1'b1;
        end
        chk("check_start_seen", found, 1'b1);
        bus.check_done = 1'b1;
        @(negedge clk);
        bus.check_done = 1'b0;
        model_apply(OP_CHECK, 8'h00);
        model_apply(OP_CDONE, 8'h00);
        chk("same_cycle_done_state", bus.state_o, 2);
        chk("same_cycle_done_run_en", bus.run_en, 1);
        bus.but_check = 1'b0;
        wait_cyc(HOLD);
        check_model("same_cycle_done");

        reset_dut();
        for (int n = 0; n < 80; n++) begin
            op_e op;
            logic [7:0] d;
            int r = $urandom_range(0, 9);
            d = 8'($urandom);
            case (r)
                5:       op = OP_CHECK;
                6:       op = OP_GLITCH;
                7:       op = OP_CDONE;
                8:       op = OP_RDONE;
                default: op = OP_LOAD;
            endcase
            do_op(op, d);
            model_apply(op, d);
            check_model($sformatf("rnd%0d", n));
        end

        chk("check_start_width", cs_wide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
